pass_attempt_controller: RTL
============================

# pass_attempt_controller

Sequencing controller wrapped around the 2-bit password comparator of the SmartHomeSystem door path. It captures a user password on a submit strobe, runs one comparison against the stored system key, and drives a timed unlock window. It counts consecutive failures and enforces a timed lockout with alarm after too many wrong attempts. It sits between the keypad/switch input logic and the door actuator and alarm outputs.

## Interface
- `MAX_TRIES`, default 3: number of consecutive failures that triggers lockout; legal range 1..7.
- `UNLOCK_CYCLES`, default 8: cycles `unlock` stays high after a correct password; must be ≥1.
- `LOCK_CYCLES`, default 16: cycles spent in lockout; must be ≥1.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `submit`  in  1: attempt strobe; sampled only in IDLE.
- `pass`  in  2: user password; sampled with `submit`.
- `key`  in  2: system password; sampled with `submit`.
- `lock_req`  in  1: manual relock; ends a GRANT window early.
- `unlock`  out  1: door-open command; high throughout GRANT.
- `deny`  out  1: one-cycle pulse for each wrong attempt that does not cause lockout.
- `alarm`  out  1: high throughout LOCKED.
- `busy`  out  1: high in every state except IDLE.
- `fail_cnt`  out  3: consecutive-failure count, range 0..MAX_TRIES-1 between attempts.

## Operation
- States: IDLE, CHECK, GRANT, DENY, LOCKED. All outputs are registered, or decoded from state and registers only.
- IDLE:
  - `submit`=1 captures `pass`/`key` into `pass_q`/`key_q` and moves to CHECK.
  - `lock_req` is ignored.
- CHECK lasts exactly one cycle. With `eq` = (`pass_q` == `key_q`) bitwise:
  - `eq`=1 → GRANT. Clear `fail_cnt`; load timer with UNLOCK_CYCLES-1.
  - `eq`=0 and `fail_cnt`+1 < MAX_TRIES → DENY. Increment `fail_cnt`.
  - `eq`=0 and `fail_cnt`+1 == MAX_TRIES → LOCKED. Load timer with LOCK_CYCLES-1; `fail_cnt` is cleared on entry.
- GRANT:
  - `unlock`=1. The timer decrements each cycle; on timer==0 → IDLE.
  - `lock_req`=1 → IDLE at the next edge, regardless of timer. `lock_req` has priority over timer expiry; both lead to IDLE.
- DENY lasts one cycle with `deny`=1, then → IDLE.
- LOCKED: `alarm`=1; the timer decrements; on timer==0 → IDLE.
- `submit` outside IDLE is dropped. It is not queued, and a held `submit` does not retrigger until the FSM is back in IDLE.
- Reset (`rst_n`=0 at an edge), including mid-GRANT or mid-LOCKED:
  - state=IDLE, timer=0, `fail_cnt`=0, `pass_q`=`key_q`=0.
  - `unlock`=`deny`=`alarm`=`busy`=0.
- Timer width is $clog2(max(UNLOCK_CYCLES, LOCK_CYCLES)). Decrement never wraps below 0.

## Timing
- Edge t: `submit` sampled in IDLE. Edge t+1: CHECK resolves. From cycle t+1, `busy`=1.
- From edge t+2:
  - `unlock` is high for exactly UNLOCK_CYCLES cycles, or until `lock_req`.
  - Or `deny` is high for 1 cycle.
  - Or `alarm` is high for exactly LOCK_CYCLES cycles.
- Back-to-back throughput: a new `submit` is accepted at the first edge where the state is IDLE. Minimum spacing for wrong attempts is 3 cycles (IDLE→CHECK→DENY→IDLE).
- `fail_cnt` updates on the CHECK→next edge.

## Structure
- Shared package `smart_home_pkg`:
  - state enum `pac_state_t` (IDLE=0, CHECK=1, GRANT=2, DENY=3, LOCKED=4, 3-bit encoding).
  - default constants for MAX_TRIES, UNLOCK_CYCLES, LOCK_CYCLES.
- Sub-module `lockout_timer`: a loadable down-counter with `load`, `load_val`, `en`, and `zero` outputs, shared by the GRANT and LOCKED states.
- The equality compare is instantiated from the existing PassCheckUnit comparator on `pass_q`/`key_q`.

## Test plan
- Reset, then `pass`=2'b10, `key`=2'b10, `submit` for 1 cycle → `busy` from t+1; `unlock`=1 for cycles t+2..t+9; back to IDLE; `fail_cnt`=0.
- `pass`=01, `key`=10 submitted twice → `deny` pulses at t+2 each time; `fail_cnt` = 1 then 2; `alarm`=0.
- A third wrong attempt → `alarm`=1 for 16 cycles, no `deny` pulse, `fail_cnt`=0; a `submit` during LOCKED is ignored with no state change.
- Correct password, then `lock_req` on the 3rd GRANT cycle → `unlock` drops at the next edge; `submit` held high continuously re-enters CHECK only once IDLE is reached.
- `rst_n`=0 mid-LOCKED (`alarm`=1) → at the next edge all outputs are 0 and `fail_cnt`=0; a subsequent correct submit unlocks normally.
- One wrong attempt, then a correct one → `fail_cnt` goes 1 → 0; the next two wrong attempts give `deny` without lockout.

Source files
------------

// File: rtl/smart_home_pkg.sv
// Shared types and default timing constants for the SmartHomeSystem door path.
package smart_home_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        GRANT  = 3'd2,
        DENY   = 3'd3,
        LOCKED = 3'd4
    } pac_state_t;

    localparam int DEF_MAX_TRIES     = 3;
    localparam int DEF_UNLOCK_CYCLES = 8;
    localparam int DEF_LOCK_CYCLES   = 16;

endpackage

// File: rtl/PassCheckUnit.sv
// 2-bit password comparator: eq is high when the user password matches the key.
module PassCheckUnit (
    input  logic [1:0] pass,
    input  logic [1:0] key,
    output logic       eq
);

    assign eq = (pass == key);

endmodule

// File: rtl/lockout_timer.sv
// Loadable down-counter shared by the unlock window and the lockout period.
module lockout_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [TW-1:0] count;

    // Load wins over decrement; the count saturates at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pass_attempt_controller.sv
// Door-path attempt sequencer: captures a password, compares it once, then
// drives a timed unlock window or counts failures up to a timed alarm lockout.
//
//  state  | meaning
//  IDLE   | waiting for submit; captures pass/key when it arrives
//  CHECK  | one cycle: compare result decides the next state
//  GRANT  | unlock high until timer expires or lock_req
//  DENY   | one-cycle deny pulse for a wrong attempt below the limit
//  LOCKED | alarm high until the lockout timer expires
module pass_attempt_controller
    import smart_home_pkg::*;
#(
    parameter int MAX_TRIES     = DEF_MAX_TRIES,
    parameter int UNLOCK_CYCLES = DEF_UNLOCK_CYCLES,
    parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       submit,
    input  logic [1:0] pass,
    input  logic [1:0] key,
    input  logic       lock_req,
    output logic       unlock,
    output logic       deny,
    output logic       alarm,
    output logic       busy,
    output logic [2:0] fail_cnt
);

    localparam int MAX_CYC = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    pac_state_t    state, state_nxt;
    logic [1:0]    pass_q, key_q;
    logic [2:0]    fail_q, fail_nxt;
    logic [3:0]    fail_inc;
    logic          eq;
    logic          tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0] tmr_load_val;

    PassCheckUnit u_cmp (
        .pass (pass_q),
        .key  (key_q),
        .eq   (eq)
    );

    lockout_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Widened by one bit so the limit compare cannot overflow at MAX_TRIES=7.
    assign fail_inc = {1'b0, fail_q} + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            pass_q <= '0;
            key_q  <= '0;
            fail_q <= '0;
        end else begin
            state  <= state_nxt;
            fail_q <= fail_nxt;
            if ((state == IDLE) && submit) begin
                pass_q <= pass;
                key_q  <= key;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        fail_nxt     = fail_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        case (state)
            IDLE: begin
                if (submit) state_nxt = CHECK;
            end
            CHECK: begin
                if (eq) begin
                    state_nxt    = GRANT;
                    fail_nxt     = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(UNLOCK_CYCLES - 1);
                end else if (fail_inc < 4'(MAX_TRIES)) begin
                    state_nxt = DENY;
                    fail_nxt  = fail_inc[2:0];
                end else begin
                    state_nxt    = LOCKED;
                    fail_nxt     = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(LOCK_CYCLES - 1);
                end
            end
            GRANT: begin
                tmr_en = 1'b1;
                if (lock_req || tmr_zero) state_nxt = IDLE;
            end
            DENY: begin
                state_nxt = IDLE;
            end
            LOCKED: begin
                tmr_en = 1'b1;
                if (tmr_zero) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign unlock   = (state == GRANT);
    assign deny     = (state == DENY);
    assign alarm    = (state == LOCKED);
    assign busy     = (state != IDLE);
    assign fail_cnt = fail_q;

endmodule
